// File: rtl/operand_entry.sv
// Purpose : chunk-wise operand entry for an ALU front panel; holds NUM_OPS operands, latches the result, drives a display word.
// Latency : every write, step-back or state change is visible one cycle after the edge; visualizar is combinational from registers.
// Backpressure: none; load/back pulses are ignored when they are not meaningful (both high, READY state, pointer at 0).
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-low reset
//   data_in, load   chunk value and write strobe for the current slot
//   back            step the slot pointer back one and zero that chunk
//   clear           synchronous clear, same effect as reset, highest priority
//   show_lo         display lower (1) or upper (0) half of the selected word
//   resultado       ALU result, captured when res_valid is high in READY
//   ops             operands, operand 0 in the LSB slice
//   estado          global slot pointer p
//   ready           all operands entered and waiting for the result
//   visualizar      {tag byte, selected half-word}
module operand_entry #(
    parameter int DATA_W  = 32,
    parameter int CHUNK_W = 8,
    parameter int NUM_OPS = 2,
    parameter int DISP_W  = DATA_W/2 + 8
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [CHUNK_W-1:0]                            data_in,
    input  logic                                          load,
    input  logic                                          back,
    input  logic                                          clear,
    input  logic                                          show_lo,
    input  logic [DATA_W-1:0]                             resultado,
    input  logic                                          res_valid,
    output logic [NUM_OPS*DATA_W-1:0]                     ops,
    output logic [$clog2(NUM_OPS*DATA_W/CHUNK_W+1)-1:0]   estado,
    output logic                                          ready,
    output logic [DISP_W-1:0]                             visualizar
);

    localparam int NCH  = DATA_W / CHUNK_W;
    localparam int PMAX = NUM_OPS * NCH;
    localparam int PW   = $clog2(PMAX + 1);
    localparam int HALF = DATA_W / 2;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_READY = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [PW-1:0]              p_q, p_d;
    logic [NUM_OPS*DATA_W-1:0]  ops_q, ops_d;
    logic [DATA_W-1:0]          res_q, res_d;

    // A simultaneous load and back cancel each other in every state.
    logic ld, bk;
    assign ld = load & ~back;
    assign bk = back & ~load;

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        ops_d   = ops_q;
        res_d   = res_q;
        if (clear) begin
            state_d = ST_LOAD;
            p_d     = '0;
            ops_d   = '0;
            res_d   = '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (ld) begin
                        // Slot s lands in operand s/NCH, chunks filled MSB first.
                        for (int s = 0; s < PMAX; s++) begin
                            if (p_q == PW'(s)) begin
                                ops_d[(s/NCH)*DATA_W + DATA_W-1 - (s%NCH)*CHUNK_W -: CHUNK_W] = data_in;
                            end
                        end
                        p_d = p_q + PW'(1);
                        if (p_q == PW'(PMAX-1)) begin
                            state_d = ST_READY;
                        end
                    end else if (bk && (p_q != '0)) begin
                        p_d = p_q - PW'(1);
                        for (int s = 0; s < PMAX; s++) begin
                            if (p_d == PW'(s)) begin
                                ops_d[(s/NCH)*DATA_W + DATA_W-1 - (s%NCH)*CHUNK_W -: CHUNK_W] = '0;
                            end
                        end
                    end
                end
                ST_READY: begin
                    if (res_valid) begin
                        res_d   = resultado;
                        state_d = ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    // A load here only starts a fresh entry; data_in is not written.
                    if (ld) begin
                        ops_d   = '0;
                        p_d     = '0;
                        state_d = ST_LOAD;
                    end else if (bk) begin
                        state_d = ST_READY;
                    end
                end
                default: begin
                    state_d = ST_LOAD;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_LOAD;
            p_q     <= '0;
            ops_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            ops_q   <= ops_d;
            res_q   <= res_d;
        end
    end

    // Display: in READY p sits at PMAX, so clamp to the last slot to keep
    // showing the final operand rather than an out-of-range index.
    logic [PW-1:0]     p_clamp;
    logic [DATA_W-1:0] sel_v;
    logic [DATA_W-1:0] disp_v;
    logic [3:0]        op_idx;
    logic [3:0]        ch_idx;
    logic [7:0]        tag;

    assign p_clamp = (p_q >= PW'(PMAX)) ? PW'(PMAX-1) : p_q;

    always_comb begin
        sel_v  = '0;
        op_idx = '0;
        ch_idx = '0;
        for (int s = 0; s < PMAX; s++) begin
            if (p_clamp == PW'(s)) begin
                sel_v  = ops_q[(s/NCH)*DATA_W +: DATA_W];
                op_idx = 4'(s/NCH);
                ch_idx = 4'(s%NCH);
            end
        end
    end

    assign disp_v     = (state_q == ST_SHOW) ? res_q : sel_v;
    assign tag        = (state_q == ST_SHOW) ? 8'hF0 : {op_idx, ch_idx};
    assign visualizar = {tag, (show_lo ? disp_v[HALF-1:0] : disp_v[DATA_W-1:HALF])};

    assign ops    = ops_q;
    assign estado = p_q;
    assign ready  = (state_q == ST_READY);

endmodule

// File: tb/tb_operand_entry.sv
module tb_operand_entry;
    localparam int DATA_W  = 32;
    localparam int CHUNK_W = 8;
    localparam int NUM_OPS = 2;
    localparam int DISP_W  = DATA_W/2 + 8;
    localparam int NCH     = DATA_W / CHUNK_W;
    localparam int PMAX    = NUM_OPS * NCH;

    logic                        clk = 1'b0;
    logic                        reset = 1'b1;
    logic [CHUNK_W-1:0]          data_in = '0;
    logic                        load = 1'b0, back = 1'b0, clear = 1'b0;
    logic                        show_lo = 1'b0, res_valid = 1'b0;
    logic [DATA_W-1:0]           resultado = '0;
    logic [NUM_OPS*DATA_W-1:0]   ops;
    logic [3:0]                  estado;
    logic                        ready;
    logic [DISP_W-1:0]           visualizar;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    operand_entry #(.DATA_W(DATA_W), .CHUNK_W(CHUNK_W), .NUM_OPS(NUM_OPS), .DISP_W(DISP_W)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .load(load), .back(back),
        .clear(clear), .show_lo(show_lo), .resultado(resultado), .res_valid(res_valid),
        .ops(ops), .estado(estado), .ready(ready), .visualizar(visualizar)
    );

    // Reference model: operands as words, p as an integer, mode 0=LOAD 1=READY 2=SHOW.
    logic [DATA_W-1:0] m_op [NUM_OPS];
    int                m_p;
    int                m_st;
    logic [DATA_W-1:0] m_res;

    function automatic void m_clear();
        for (int i = 0; i < NUM_OPS; i++) m_op[i] = '0;
        m_p = 0; m_st = 0; m_res = '0;
    endfunction

    function automatic void m_set_chunk(int slot, logic [CHUNK_W-1:0] v);
        int sh;
        sh = DATA_W - CHUNK_W * (slot % NCH + 1);
        m_op[slot/NCH] = (m_op[slot/NCH] & ~(32'hFF << sh)) | (DATA_W'(v) << sh);
    endfunction

    function automatic void m_step();
        bit l, b;
        l = load && !back;
        b = back && !load;
        if (!reset || clear) m_clear();
        else if (m_st == 0) begin
            if (l) begin
                m_set_chunk(m_p, data_in);
                m_p = m_p + 1;
                if (m_p == PMAX) m_st = 1;
            end else if (b && m_p > 0) begin
                m_p = m_p - 1;
                m_set_chunk(m_p, '0);
            end
        end else if (m_st == 1) begin
            if (res_valid) begin m_res = resultado; m_st = 2; end
        end else begin
            if (l) begin
                for (int i = 0; i < NUM_OPS; i++) m_op[i] = '0;
                m_p = 0; m_st = 0;
            end else if (b) m_st = 1;
        end
    endfunction

    function automatic logic [NUM_OPS*DATA_W-1:0] m_ops();
        logic [NUM_OPS*DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_OPS; i++) r = r | ((NUM_OPS*DATA_W)'(m_op[i]) << (i*DATA_W));
        return r;
    endfunction

    function automatic logic [DISP_W-1:0] m_disp();
        logic [DATA_W-1:0] v;
        logic [7:0] t;
        int q;
        if (m_st == 2) begin v = m_res; t = 8'hF0; end
        else begin
            q = (m_p < PMAX - 1) ? m_p : PMAX - 1;
            v = m_op[q/NCH];
            t = {4'(q/NCH), 4'(q%NCH)};
        end
        return {t, (show_lo ? v[DATA_W/2-1:0] : v[DATA_W-1:DATA_W/2])};
    endfunction

    // One clock with the given inputs held across the edge; outputs settle by #1.
    task automatic cyc(input bit l, input bit b, input bit c, input bit rv,
                       input logic [CHUNK_W-1:0] d, input logic [DATA_W-1:0] r, input bit rst_n);
        load = l; back = b; clear = c; res_valid = rv; data_in = d; resultado = r; reset = rst_n;
        @(posedge clk);
        m_step();
        #1;
        load = 0; back = 0; clear = 0; res_valid = 0; reset = 1;
    endtask

    task automatic test_reset();
        cyc(0, 0, 0, 0, 8'h00, '0, 0);
        show_lo = 0; #1;
        checks++; if (ops !== 64'h0) begin failures++; $display("FAIL reset_ops got=%h exp=%h", ops, 64'h0); end
        checks++; if (estado !== 4'd0) begin failures++; $display("FAIL reset_estado got=%0d exp=0", estado); end
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ready); end
        checks++; if (visualizar !== 24'h000000) begin failures++; $display("FAIL reset_vis got=%h exp=000000", visualizar); end
    endtask

    task automatic test_entry();
        logic [7:0] seq [8];
        seq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 8; i++) begin
            cyc(1, 0, 0, 0, seq[i], '0, 1);
            if (i == 6) begin
                checks++; if (ready !== 1'b0) begin failures++; $display("FAIL entry_ready_early got=%b exp=0", ready); end
            end
        end
        show_lo = 0; #1;
        checks++; if (ops[31:0] !== 32'hAABBCCDD) begin failures++; $display("FAIL entry_A got=%h exp=AABBCCDD", ops[31:0]); end
        checks++; if (ops[63:32] !== 32'h11223344) begin failures++; $display("FAIL entry_B got=%h exp=11223344", ops[63:32]); end
        checks++; if (estado !== 4'd8) begin failures++; $display("FAIL entry_estado got=%0d exp=8", estado); end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL entry_ready got=%b exp=1", ready); end
        checks++; if (visualizar !== 24'h131122) begin failures++; $display("FAIL entry_vis got=%h exp=131122", visualizar); end
    endtask

    task automatic test_ready_ignore();
        cyc(1, 0, 0, 0, 8'h55, '0, 1);
        cyc(0, 1, 0, 0, 8'h66, '0, 1);
        cyc(1, 1, 0, 0, 8'h77, '0, 1);
        checks++; if (ops !== 64'h11223344_AABBCCDD) begin failures++; $display("FAIL ready_ops got=%h exp=11223344aabbccdd", ops); end
        checks++; if (estado !== 4'd8 || ready !== 1'b1) begin failures++; $display("FAIL ready_hold got=%0d/%b exp=8/1", estado, ready); end
    endtask

    task automatic test_result();
        cyc(0, 0, 0, 1, 8'h00, 32'hCAFEBABE, 1);
        show_lo = 0; #1;
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL show_ready got=%b exp=0", ready); end
        checks++; if (visualizar !== 24'hF0CAFE) begin failures++; $display("FAIL show_vis_hi got=%h exp=F0CAFE", visualizar); end
        show_lo = 1; #1;
        checks++; if (visualizar !== 24'hF0BABE) begin failures++; $display("FAIL show_vis_lo got=%h exp=F0BABE", visualizar); end
        cyc(0, 0, 0, 1, 8'h00, 32'hDEADBEEF, 1);
        checks++; if (visualizar !== 24'hF0BABE) begin failures++; $display("FAIL show_resvalid_ignored got=%h exp=F0BABE", visualizar); end
        cyc(0, 1, 0, 0, 8'h00, '0, 1);
        checks++; if (ready !== 1'b1 || estado !== 4'd8) begin failures++; $display("FAIL show_back got=%b/%0d exp=1/8", ready, estado); end
        cyc(0, 0, 0, 1, 8'h00, 32'h12345678, 1);
        checks++; if (visualizar !== 24'hF05678) begin failures++; $display("FAIL show_relatch got=%h exp=F05678", visualizar); end
    endtask

    task automatic test_show_reload();
        cyc(1, 0, 0, 0, 8'h99, '0, 1);
        checks++; if (ops !== 64'h0 || estado !== 4'd0 || ready !== 1'b0) begin
            failures++; $display("FAIL reload_clear got=%h/%0d/%b exp=0/0/0", ops, estado, ready); end
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0, 8'(8'h10 + i), '0, 1);
        checks++; if (ops !== 64'h14151617_10111213 || ready !== 1'b1) begin
            failures++; $display("FAIL reload_full got=%h/%b exp=1415161710111213/1", ops, ready); end
    endtask

    task automatic test_clear_show();
        cyc(0, 0, 0, 1, 8'h00, 32'h0BADF00D, 1);
        cyc(1, 0, 1, 1, 8'hEE, 32'h1, 1);
        checks++; if (ops !== 64'h0 || estado !== 4'd0 || ready !== 1'b0 || visualizar !== 24'h0) begin
            failures++; $display("FAIL clear_show got=%h/%0d/%b/%h exp=0/0/0/000000", ops, estado, ready, visualizar); end
    endtask

    task automatic test_back();
        cyc(1, 0, 0, 0, 8'hAA, '0, 1);
        cyc(1, 0, 0, 0, 8'hBB, '0, 1);
        cyc(0, 1, 0, 0, 8'h00, '0, 1);
        cyc(1, 0, 0, 0, 8'hCC, '0, 1);
        checks++; if (ops[31:0] !== 32'hAACC0000 || estado !== 4'd2) begin
            failures++; $display("FAIL back_edit got=%h/%0d exp=AACC0000/2", ops[31:0], estado); end
        cyc(0, 0, 0, 0, 8'h00, '0, 0);
        cyc(0, 1, 0, 0, 8'h00, '0, 1);
        checks++; if (estado !== 4'd0) begin failures++; $display("FAIL back_at_zero got=%0d exp=0", estado); end
    endtask

    task automatic test_conflict();
        cyc(1, 0, 0, 0, 8'h01, '0, 1);
        cyc(1, 0, 0, 0, 8'h02, '0, 1);
        cyc(1, 0, 0, 0, 8'h03, '0, 1);
        cyc(1, 1, 0, 0, 8'h77, '0, 1);
        checks++; if (ops !== 64'h00000000_01020300 || estado !== 4'd3) begin
            failures++; $display("FAIL conflict got=%h/%0d exp=0000000001020300/3", ops, estado); end
    endtask

    task automatic test_midreset();
        cyc(0, 0, 0, 0, 8'h00, '0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 8'(8'hA0 + i), '0, 1);
        cyc(1, 0, 0, 0, 8'hFF, '0, 0);
        checks++; if (ops !== 64'h0 || estado !== 4'd0 || ready !== 1'b0) begin
            failures++; $display("FAIL midreset got=%h/%0d/%b exp=0/0/0", ops, estado, ready); end
        cyc(1, 0, 0, 0, 8'h5A, '0, 1);
        checks++; if (ops !== 64'h00000000_5A000000 || estado !== 4'd1) begin
            failures++; $display("FAIL midreset_next got=%h/%0d exp=000000005A000000/1", ops, estado); end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int n = 0; n < 1500; n++) begin
            int r;
            bit l, b, c, rv, rs;
            r  = $urandom_range(0, 99);
            l  = (r < 50) || (r >= 95);
            b  = (r >= 50 && r < 65) || (r >= 95);
            rv = ($urandom_range(0, 99) < 25);
            c  = ($urandom_range(0, 99) < 2);
            rs = ($urandom_range(0, 199) == 0);
            show_lo = 1'($urandom_range(0, 1));
            cyc(l, b, c, rv, 8'($urandom), $urandom, !rs);
            checks++;
            if (ops !== m_ops() || estado !== 4'(m_p) || ready !== (m_st == 1) || visualizar !== m_disp()) begin
                failures++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random n=%0d got ops=%h p=%0d rdy=%b vis=%h exp ops=%h p=%0d rdy=%b vis=%h",
                             n, ops, estado, ready, visualizar, m_ops(), m_p, (m_st == 1), m_disp());
            end
        end
    endtask

    initial begin
        test_reset();
        test_entry();
        test_ready_ignore();
        test_result();
        test_show_reload();
        test_clear_show();
        test_back();
        test_conflict();
        test_midreset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/operand_entry.md
OPERAND_ENTRY -- requirements
Module: operand_entry

Interface
REQ-001 The block SHALL have these parameters:
  DATA_W, 32, operand and result width in bits
  CHUNK_W, 8, bits entered per load pulse; DATA_W SHALL be a multiple of CHUNK_W
  NUM_OPS, 2, number of operands (2..4)
  DISP_W, DATA_W/2+8, display bus width; fixed by DATA_W
REQ-002 The block SHALL have these ports; one clock, reset synchronous active-low:
  clk  input  1  rising-edge clock
  reset  input  1  synchronous active-low reset
  data_in  input  CHUNK_W  switch value for the current chunk
  load  input  1  single-cycle pulse; write data_in to the current slot
  back  input  1  single-cycle pulse; step back one slot
  clear  input  1  synchronous clear, same effect as reset
  show_lo  input  1  0 = display upper half, 1 = lower half
  resultado  input  DATA_W  result from the ALU
  res_valid  input  1  resultado valid this cycle
  ops  output  NUM_OPS*DATA_W  operands; operand 0 (A) in the LSB slice
  estado  output  clog2(NUM_OPS*DATA_W/CHUNK_W+1)  global slot pointer
  ready  output  1  all operands loaded and waiting for the result
  visualizar  output  DISP_W  display word

Function
REQ-003 NCH = DATA_W/CHUNK_W. Slot p maps to operand p/NCH, chunk p%NCH; PMAX = NUM_OPS*NCH.
REQ-004 The FSM SHALL have three states: LOAD, READY and SHOW.
REQ-005 LOAD: a load pulse SHALL write data_in to operand[p/NCH] bits [DATA_W-1-(p%NCH)*CHUNK_W -: CHUNK_W], MSB chunk first, and increment p. The write is visible the cycle after the edge.
REQ-006 LOAD: a load pulse on slot PMAX-1 SHALL write, set p=PMAX and move to READY. ready SHALL be 1 from the next cycle.
REQ-007 LOAD: a back pulse with p>0 SHALL decrement p and zero the chunk at the new p. With p=0, back SHALL be ignored.
REQ-008 load and back high in the same cycle SHALL both be ignored in every state.
REQ-009 READY: load and back SHALL be ignored. res_valid=1 SHALL latch resultado into res_reg, clear ready and move to SHOW on the same edge.
REQ-010 SHOW: a load pulse SHALL zero all operands, set p=0 and move to LOAD; that pulse does not write data_in. back in SHOW SHALL return to READY with res_reg retained.
REQ-011 res_valid outside READY SHALL be ignored; res_reg changes only on the READY->SHOW transition.
REQ-012 visualizar (combinational from registers), with H = show_lo ? V[DATA_W/2-1:0] : V[DATA_W-1:DATA_W/2]:
  LOAD/READY: {4-bit operand index, 4-bit chunk index, H}, where V = operand[min(p,PMAX-1)/NCH]
  SHOW: {8'hF0, H}, where V = res_reg
REQ-013 estado SHALL equal p in every state.
REQ-014 clear=1 SHALL take priority over load, back and res_valid.

Reset
REQ-015 reset=0 at a rising edge SHALL set state=LOAD, p=0, ops=0, res_reg=0, ready=0. visualizar then reads 0x000000.
REQ-016 Reset or clear mid-entry, or in READY/SHOW, SHALL discard all partial data with no residual write.

Verification (defaults: DATA_W=32, CHUNK_W=8, NUM_OPS=2)
REQ-017 Load pulses AA,BB,CC,DD,11,22,33,44 -> A=AABBCCDD, B=11223344, estado=8, ready=1 the cycle after the 8th pulse.
REQ-018 In READY, res_valid with resultado=CAFEBABE -> SHOW, ready=0. show_lo=0 -> visualizar=F0CAFE; show_lo=1 -> F0BABE.
REQ-019 Load AA,BB, then back, then CC -> A=AACC0000, estado=2. Back at p=0 -> estado stays 0.
REQ-020 load and back together at p=3 -> no change. Load pulses in READY -> ops unchanged.
REQ-021 reset=0 after 5 chunks (or clear=1 in SHOW) -> ops=0, estado=0, ready=0, state LOAD. The next load writes chunk 0 of A.
REQ-022 From SHOW, load pulse -> LOAD with ops=0; a subsequent full entry of 8 chunks reaches READY again.
